// File: rtl/i2c_config_sequencer.sv
// Register-init table walker feeding i2c_write_reg_multi: pushes each
// entry's bytes into the writer FIFO, starts it, and retries on failure.
module i2c_config_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int MAX_BYTES   = 8,
  parameter int MAX_RETRIES = 3,
  parameter int WAIT_CYCLES = 1 << 20,
  parameter int BACKOFF     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [6:0]        dev_address,
  output logic [ADDR_W-1:0] table_addr,
  input  logic [15:0]       table_data,
  output logic              wr_start,
  output logic [6:0]        wr_dev_address,
  output logic [7:0]        wr_reg_address,
  output logic [3:0]        wr_byte_width,
  output logic [7:0]        fifo_data,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_write_ack,
  output logic              fifo_flush,
  input  logic              wr_done,
  input  logic              wr_failure,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_entry
);

  localparam int TW = $clog2(WAIT_CYCLES + 1);
  localparam int BW = $clog2(BACKOFF + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_PUSH, S_ACK, S_START,
    S_WAIT, S_FAIL, S_BACKOFF, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic              r_wait;
  logic [3:0]        r_cnt;
  logic [RW-1:0]     r_retry;
  logic [TW-1:0]     r_tmo;
  logic [BW-1:0]     r_bo;
  logic [ADDR_W-1:0] r_hdr_addr;
  logic              r_done_q;
  logic              r_fail_q;

  logic [3:0] w_width;
  logic       w_done_rise;
  logic       w_fail_rise;
  logic       w_bad_width;

  assign w_width     = table_data[11:8];
  assign w_bad_width = (w_width == 4'd0) || (w_width > 4'(MAX_BYTES));
  assign w_done_rise = wr_done & ~r_done_q;
  assign w_fail_rise = wr_failure & ~r_fail_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wait         <= 1'b0;
      r_cnt          <= '0;
      r_retry        <= '0;
      r_tmo          <= '0;
      r_bo           <= '0;
      r_hdr_addr     <= '0;
      r_done_q       <= 1'b0;
      r_fail_q       <= 1'b0;
      table_addr     <= '0;
      wr_start       <= 1'b0;
      wr_dev_address <= '0;
      wr_reg_address <= '0;
      wr_byte_width  <= '0;
      fifo_data      <= '0;
      fifo_wr_en     <= 1'b0;
      fifo_flush     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_entry      <= '0;
    end else begin
      wr_start       <= 1'b0;
      fifo_wr_en     <= 1'b0;
      fifo_flush     <= 1'b0;
      wr_dev_address <= dev_address;
      // Previous levels track every cycle, so START also seeds them
      r_done_q       <= wr_done;
      r_fail_q       <= wr_failure;
      unique case (r_state)
        S_IDLE: if (go) begin
          done       <= 1'b0;
          error      <= 1'b0;
          busy       <= 1'b1;
          table_addr <= '0;
          r_retry    <= '0;
          r_wait     <= 1'b0;
          r_state    <= S_HDR;
        end
        S_HDR: if (!r_wait) begin
          r_wait <= 1'b1;
        end else begin
          r_wait     <= 1'b0;
          r_hdr_addr <= table_addr;
          if (table_data[15]) begin
            r_state <= S_DONE;
          end else if (w_bad_width || table_addr == AMAX) begin
            r_state <= S_ERR;
          end else begin
            wr_reg_address <= table_data[7:0];
            wr_byte_width  <= w_width;
            r_cnt          <= w_width;
            table_addr     <= table_addr + 1'b1;
            r_state        <= S_PUSH;
          end
        end
        S_PUSH: if (!r_wait) begin
          r_wait <= 1'b1;
        end else begin
          r_wait <= 1'b0;
          if (fifo_full || table_addr == AMAX) begin
            r_state <= S_ERR;
          end else begin
            fifo_data  <= table_data[7:0];
            fifo_wr_en <= 1'b1;
            table_addr <= table_addr + 1'b1;
            r_cnt      <= r_cnt - 1'b1;
            r_state    <= S_ACK;
          end
        end
        // Ack is registered by the writer: check one cycle after the strobe
        S_ACK: if (!r_wait) begin
          r_wait <= 1'b1;
        end else begin
          r_wait <= 1'b0;
          if (!fifo_write_ack) r_state <= S_ERR;
          else if (r_cnt == 4'd0) r_state <= S_START;
          else r_state <= S_PUSH;
        end
        S_START: begin
          wr_start <= 1'b1;
          r_tmo    <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_fail_rise || r_tmo == TW'(WAIT_CYCLES)) begin
            r_state <= S_FAIL;
          end else if (w_done_rise) begin
            r_retry <= '0;
            r_wait  <= 1'b0;
            r_state <= S_HDR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_FAIL: begin
          fifo_flush <= 1'b1;
          r_retry    <= r_retry + 1'b1;
          if (r_retry + 1'b1 == RW'(MAX_RETRIES)) begin
            r_state <= S_ERR;
          end else begin
            table_addr <= r_hdr_addr;
            r_bo       <= '0;
            r_state    <= S_BACKOFF;
          end
        end
        S_BACKOFF: begin
          if (r_bo == BW'(BACKOFF - 1)) begin
            r_wait  <= 1'b0;
            r_state <= S_HDR;
          end else begin
            r_bo <= r_bo + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          error      <= 1'b1;
          err_entry  <= r_hdr_addr;
          fifo_flush <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: a table-level model predicts
// FIFO bytes, start pulses and flushes; a negedge monitor compares them.
module tb_i2c_config_sequencer;

  localparam int AW = 6;
  localparam int MB = 8;
  localparam int MR = 3;
  localparam int WC = 300;
  localparam int BO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [6:0]    dev_address = '0;
  logic [AW-1:0] table_addr;
  logic [15:0]   table_data = '0;
  logic          wr_start;
  logic [6:0]    wr_dev_address;
  logic [7:0]    wr_reg_address;
  logic [3:0]    wr_byte_width;
  logic [7:0]    fifo_data;
  logic          fifo_wr_en;
  logic          fifo_full = 1'b0;
  logic          fifo_write_ack = 1'b0;
  logic          fifo_flush;
  logic          wr_done = 1'b0;
  logic          wr_failure = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_entry;

  i2c_config_sequencer #(
    .ADDR_W(AW), .MAX_BYTES(MB), .MAX_RETRIES(MR),
    .WAIT_CYCLES(WC), .BACKOFF(BO)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .dev_address(dev_address), .table_addr(table_addr),
    .table_data(table_data), .wr_start(wr_start),
    .wr_dev_address(wr_dev_address),
    .wr_reg_address(wr_reg_address),
    .wr_byte_width(wr_byte_width), .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_write_ack(fifo_write_ack), .fifo_flush(fifo_flush),
    .wr_done(wr_done), .wr_failure(wr_failure), .busy(busy),
    .done(done), .error(error), .err_entry(err_entry)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [64];
  always @(posedge clk) table_data <= rom[table_addr];
  always @(posedge clk) fifo_write_ack <= fifo_wr_en & ~fifo_full;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Event kinds: 0 byte, 1 start, 2 flush (data: 0 timeout, 1 failure, 2 error)
  int          exp_k [$];
  logic [23:0] exp_d [$];
  int          oc_q [$];
  int          dl_q [$];
  bit          exp_done;
  bit          exp_err;
  int          exp_ee;
  int          last_ff = -1;
  int          last_st = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic push_ev(input int k, input logic [23:0] d);
    exp_k.push_back(k);
    exp_d.push_back(d);
  endtask

  task automatic see_ev(input int k, input logic [23:0] d);
    int ek;
    logic [23:0] ed;
    int gap;
    checks++;
    if (exp_k.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d got=%h required=none", k, d);
      return;
    end
    ek = exp_k.pop_front();
    ed = exp_d.pop_front();
    if (ek != k || (k != 2 && ed != d)) begin
      failures++;
      $display("FAIL event got=%0d/%h required=%0d/%h", k, d, ek, ed);
    end
    if (k == 0 && last_ff >= 0) begin
      gap = cyc - last_ff;
      last_ff = -1;
      checks++;
      if (gap < BO || gap > BO + 8) begin
        failures++;
        $display("FAIL backoff_gap got=%0d required=%0d..%0d", gap, BO, BO + 8);
      end
    end
    if (k == 1) last_st = cyc;
    if (k == 2 && ek == 2 && ed == 24'd0) begin
      gap = cyc - last_st;
      checks++;
      if (gap < WC || gap > WC + 4) begin
        failures++;
        $display("FAIL timeout_gap got=%0d required=%0d..%0d", gap, WC, WC + 4);
      end
    end
    if (k == 2 && ek == 2 && ed != 24'd2) last_ff = cyc;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_wr_en) see_ev(0, {16'd0, fifo_data});
      if (wr_start)
        see_ev(1, {5'd0, wr_dev_address, wr_reg_address, wr_byte_width});
      if (fifo_flush) see_ev(2, 24'd0);
    end
  end

  // Writer: each start consumes one scripted outcome (0 done, 1 failure, 2 silent)
  initial begin
    forever begin
      @(negedge clk);
      if (wr_start && !reset) begin
        int oc;
        int d;
        oc = 2;
        d = 0;
        if (oc_q.size() > 0) begin
          oc = oc_q.pop_front();
          d = dl_q.pop_front();
        end
        if (oc != 2) begin
          repeat (d) @(negedge clk);
          if (oc == 0) wr_done = 1'b1;
          else wr_failure = 1'b1;
          repeat (3) @(negedge clk);
          wr_done = 1'b0;
          wr_failure = 1'b0;
        end
      end
    end
  end

  // Table-level prediction: walk entries, replay attempts by outcome
  task automatic model(input bit full);
    int a;
    int k;
    int w;
    int tries;
    int oc;
    logic [15:0] h;
    a = 0;
    k = 0;
    exp_done = 0;
    exp_err = 0;
    exp_ee = 0;
    forever begin
      h = rom[a];
      if (h[15]) begin
        exp_done = 1;
        return;
      end
      w = int'(h[11:8]);
      if (w == 0 || w > MB || full) begin
        push_ev(2, 24'd2);
        exp_err = 1;
        exp_ee = a;
        return;
      end
      tries = 0;
      forever begin
        for (int i = 1; i <= w; i++) push_ev(0, {16'd0, rom[a + i][7:0]});
        push_ev(1, {5'd0, dev_address, h[7:0], 4'(w)});
        oc = (k < oc_q.size()) ? oc_q[k] : 2;
        k++;
        if (oc == 0) break;
        push_ev(2, (oc == 2) ? 24'd0 : 24'd1);
        tries++;
        if (tries == MR) begin
          push_ev(2, 24'd2);
          exp_err = 1;
          exp_ee = a;
          return;
        end
      end
      a = a + w + 1;
    end
  endtask

  task automatic load(input int widths [$]);
    int a;
    oc_q.delete();
    dl_q.delete();
    for (int i = 0; i < 64; i++) rom[i] = 16'h8000;
    a = 0;
    foreach (widths[j]) begin
      rom[a] = {4'b0, 4'(widths[j]), 8'($urandom)};
      for (int i = 1; i <= widths[j] && i <= MB; i++) rom[a + i] = 16'($urandom);
      a = a + widths[j] + 1;
    end
    rom[a] = 16'h8000 | 16'($urandom_range(0, 4095));
    dev_address = 7'($urandom);
  endtask

  task automatic add_oc(input int oc, input int d);
    oc_q.push_back(oc);
    dl_q.push_back(d);
  endtask

  task automatic run_case(input string nm, input bit full);
    bit fin;
    model(full);
    last_ff = -1;
    fifo_full = full;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    fin = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL %s_timeout busy=1 required=0", nm);
    end
    repeat (3) @(negedge clk);
    fifo_full = 1'b0;
    chk({nm, "_done"}, 32'(done), 32'(exp_done));
    chk({nm, "_error"}, 32'(error), 32'(exp_err));
    if (exp_err) chk({nm, "_err_entry"}, 32'(err_entry), 32'(exp_ee));
    chk({nm, "_pending"}, 32'(exp_k.size()), 32'd0);
    exp_k.delete();
    exp_d.delete();
  endtask

  initial begin
    int ws [$];
    int n;
    int nf;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset_outs", {26'd0, wr_start, fifo_wr_en, fifo_flush, busy, done, error}, 32'd0);
    chk("reset_addr", 32'(table_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    ws = {};
    load(ws);
    rom[0] = 16'h0210;
    rom[1] = 16'h00AA;
    rom[2] = 16'h00BB;
    rom[3] = 16'h8000;
    add_oc(0, 50);
    run_case("t1_basic", 0);

    ws = {1, 3, 8};
    load(ws);
    for (int i = 0; i < 3; i++) add_oc(0, $urandom_range(5, 100));
    run_case("t2_three", 0);

    ws = {$urandom_range(1, 8), $urandom_range(1, 8)};
    load(ws);
    add_oc(1, $urandom_range(5, 60));
    add_oc(0, $urandom_range(5, 60));
    add_oc(0, $urandom_range(5, 60));
    run_case("t3_retry", 0);

    ws = {$urandom_range(1, 8), $urandom_range(1, 8)};
    load(ws);
    add_oc(0, 10);
    run_case("t4_silent", 0);

    ws = {0};
    load(ws);
    run_case("t5_w0", 0);
    ws = {9};
    load(ws);
    run_case("t5_w9", 0);
    ws = {4};
    load(ws);
    run_case("t5_full", 1);

    ws = {3};
    load(ws);
    add_oc(2, 0);
    model(0);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_start) begin
        seen = 1;
        break;
      end
    end
    chk("t6_start_seen", 32'(seen), 32'd1);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_outs", {26'd0, wr_start, fifo_wr_en, fifo_flush, busy, done, error}, 32'd0);
    chk("t6_rst_addr", 32'(table_addr), 32'd0);
    @(negedge clk);
    exp_k.delete();
    exp_d.delete();
    reset = 1'b0;
    @(negedge clk);
    ws = {$urandom_range(1, 8), $urandom_range(1, 8)};
    load(ws);
    add_oc(0, 20);
    add_oc(0, 20);
    run_case("t6_restart", 0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      ws = {};
      for (int e = 0; e < n; e++) ws.push_back($urandom_range(1, 8));
      load(ws);
      for (int e = 0; e < n; e++) begin
        nf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        for (int f = 0; f < nf; f++)
          add_oc(($urandom_range(0, 3) == 0) ? 2 : 1, $urandom_range(2, 60));
        add_oc(0, $urandom_range(2, 120));
      end
      run_case("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
